ifetch_unit: RTL

Instruction fetch front end that consumes the PC held by the PC register and produces its next value. Issues in-order requests to instruction memory over a valid/ready handshake, tracks responses of variable latency in a small tagged buffer, and presents {instruction, PC} pairs to decode over a second valid/ready handshake. Branch/jump redirects flush the buffer and discard stale in-flight responses.

---
 rtl/ifetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: in-order imem requests, tagged response buffer, decode handshake.
// Optional misaligned-PC detection is enabled by defining IFETCH_MISALIGN_CHECK_EN.
module ifetch_unit #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] pc,
  output logic [Width-1:0] pc_next,
  input  logic             redirect,
  input  logic [Width-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [Width-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [Width-1:0] inst_pc,
  output logic             misalign_fault
);

  localparam int unsigned InstW = 32;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  typedef enum logic [0:0] {FETCH, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   occ_q, occ_d;
  logic [CntW-1:0]   pend_q, pend_d;
  logic [CntW-1:0]   stale_q, stale_d;
  logic [Width-1:0]  ent_pc_q [Depth];
  logic [Width-1:0]  ent_pc_d [Depth];
  logic [InstW-1:0]  ent_data_q [Depth];
  logic [InstW-1:0]  ent_data_d [Depth];

  logic              block_c;
  logic              req_fire_c;
  logic              pop_c;
  logic              rsp_fill_c;
  logic [PtrW-1:0]   fill_idx_c;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky until a redirect; a misaligned PC seen in FETCH raises it at the next edge.
  always_comb begin
    fault_d = fault_q;
    if (redirect) begin
      fault_d = 1'b0;
    end else if ((state_q == FETCH) && (pc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign block_c        = (pc[1:0] != 2'b00) || fault_q;
  assign misalign_fault = fault_q;
`else
  assign block_c        = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  // Entries between head and the fill point hold data; the rest await responses.
  assign fill_idx_c     = head_q + PtrW'(occ_q - pend_q);

  assign imem_req_valid = !reset && (state_q == FETCH) && (occ_q < CntW'(Depth))
                          && !redirect && !block_c;
  assign imem_req_addr  = pc;
  assign req_fire_c     = imem_req_valid && imem_req_ready;
  assign pc_next        = redirect ? redirect_pc : (req_fire_c ? pc + Width'(4) : pc);

  assign inst_valid     = (occ_q != pend_q) && !redirect;
  assign inst           = ent_data_q[head_q];
  assign inst_pc        = ent_pc_q[head_q];
  assign pop_c          = inst_valid && inst_ready;
  assign rsp_fill_c     = imem_rsp_valid && (state_q == FETCH) && !redirect && (pend_q != '0);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    stale_d    = stale_q;
    ent_pc_d   = ent_pc_q;
    ent_data_d = ent_data_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          // A response landing in the redirect cycle is dropped here, not counted as stale.
          head_d  = '0;
          tail_d  = '0;
          occ_d   = '0;
          pend_d  = '0;
          stale_d = pend_q - CntW'(imem_rsp_valid && (pend_q != '0));
          state_d = (stale_d != '0) ? DRAIN : FETCH;
        end else begin
          if (req_fire_c) begin
            ent_pc_d[tail_q] = pc;
            tail_d           = tail_q + PtrW'(1);
          end
          if (rsp_fill_c) begin
            ent_data_d[fill_idx_c] = imem_rsp_data;
          end
          if (pop_c) begin
            head_d = head_q + PtrW'(1);
          end
          occ_d  = occ_q + CntW'(req_fire_c) - CntW'(pop_c);
          pend_d = pend_q + CntW'(req_fire_c) - CntW'(rsp_fill_c);
        end
      end
      DRAIN: begin
        if (imem_rsp_valid && (stale_q != '0)) begin
          stale_d = stale_q - CntW'(1);
        end
        if (stale_d == '0) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
      stale_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        ent_pc_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      stale_q    <= stale_d;
      ent_pc_q   <= ent_pc_d;
      ent_data_q <= ent_data_d;
    end
  end

endmodule
